// File: rtl/io_cfg_pkg.sv
// Shared types and defaults for the IO cell configuration sequencer.
package io_cfg_pkg;

    localparam int DEFAULT_CONF_WIDTH = 3;

    // Parking configuration: input mode with the output driver tristated.
    localparam logic [DEFAULT_CONF_WIDTH-1:0] DEFAULT_SAFE_CFG = 3'b000;

    typedef enum logic {
        IDLE,
        SETTLE
    } io_cfg_state_e;

endpackage

// File: rtl/io_cfg_regbank.sv
// Per-pad configuration register bank with individual write enables
// and a global load of the safe configuration into every pad.
module io_cfg_regbank
    import io_cfg_pkg::*;
#(
    parameter int                     NUM_PADS   = 8,
    parameter int                     CONF_WIDTH = DEFAULT_CONF_WIDTH,
    parameter logic [CONF_WIDTH-1:0]  SAFE_CFG   = CONF_WIDTH'(DEFAULT_SAFE_CFG)
) (
    input  logic                           clk_in,
    input  logic                           reset_int,
    input  logic                           safe_load,
    input  logic [NUM_PADS-1:0]            wr_en,
    input  logic [CONF_WIDTH-1:0]          wr_data,
    output logic [NUM_PADS*CONF_WIDTH-1:0] cfg_flat
);

    // Global safe load overrides any individual pad write.
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            cfg_flat <= {NUM_PADS{SAFE_CFG}};
        end else if (safe_load) begin
            cfg_flat <= {NUM_PADS{SAFE_CFG}};
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (wr_en[i]) begin
                    cfg_flat[i*CONF_WIDTH +: CONF_WIDTH] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/io_cfg_sequencer.sv
// Sequences configuration changes of a bank of IO cells: a pad is parked
// at the safe configuration for a settle period before its new value lands.
module io_cfg_sequencer
    import io_cfg_pkg::*;
#(
    parameter int                     NUM_PADS      = 8,
    parameter int                     CONF_WIDTH    = DEFAULT_CONF_WIDTH,
    parameter logic [CONF_WIDTH-1:0]  SAFE_CFG      = CONF_WIDTH'(DEFAULT_SAFE_CFG),
    parameter int                     SETTLE_CYCLES = 4,
    parameter int                     IDX_W         = $clog2(NUM_PADS)
) (
    input  logic                           clk_in,
    input  logic                           reset_int,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [IDX_W-1:0]               req_pad_i,
    input  logic [CONF_WIDTH-1:0]          req_cfg_i,
    input  logic                           safe_all_i,
    output logic [NUM_PADS*CONF_WIDTH-1:0] io_cell_cfg_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int               CNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W:0]   NUM_PADS_W = (IDX_W + 1)'(NUM_PADS);

    io_cfg_state_e          state;
    logic [CNT_W-1:0]       settle_cnt;
    logic [IDX_W-1:0]       lat_pad;
    logic [CONF_WIDTH-1:0]  lat_cfg;

    logic                   accept;
    logic                   pad_ok;
    logic [CONF_WIDTH-1:0]  cur_cfg;
    logic                   cfg_differs;
    logic                   start_seq;
    logic                   settle_last;
    logic [NUM_PADS-1:0]    wr_en;
    logic [CONF_WIDTH-1:0]  wr_data;

    assign req_ready_o = (state == IDLE) & ~safe_all_i;
    assign accept      = req_valid_i & req_ready_o;
    assign pad_ok      = ({1'b0, req_pad_i} < NUM_PADS_W);
    assign cfg_differs = (cur_cfg != req_cfg_i);
    assign start_seq   = accept & pad_ok & cfg_differs;
    assign settle_last = (state == SETTLE) & (settle_cnt == CNT_LAST);

    // Current configuration of the requested pad; out-of-range indices never match.
    always_comb begin
        cur_cfg = SAFE_CFG;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (req_pad_i == IDX_W'(i)) begin
                cur_cfg = io_cell_cfg_o[i*CONF_WIDTH +: CONF_WIDTH];
            end
        end
    end

    // Park the target pad when a sequence starts, apply the latched value when it ends.
    always_comb begin
        wr_en   = '0;
        wr_data = settle_last ? lat_cfg : SAFE_CFG;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (start_seq && (req_pad_i == IDX_W'(i))) begin
                wr_en[i] = 1'b1;
            end
            if (settle_last && (lat_pad == IDX_W'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    io_cfg_regbank #(
        .NUM_PADS   (NUM_PADS),
        .CONF_WIDTH (CONF_WIDTH),
        .SAFE_CFG   (SAFE_CFG)
    ) u_regbank (
        .clk_in    (clk_in),
        .reset_int (reset_int),
        .safe_load (safe_all_i),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cfg_flat  (io_cell_cfg_o)
    );

    // Request FSM with settle counter; safe_all_i aborts everything and wins every edge.
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            state      <= IDLE;
            settle_cnt <= '0;
            lat_pad    <= '0;
            lat_cfg    <= SAFE_CFG;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else if (safe_all_i) begin
            state      <= IDLE;
            settle_cnt <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!pad_ok) begin
                            err_o <= 1'b1;
                        end else if (!cfg_differs) begin
                            done_o <= 1'b1;
                        end else begin
                            lat_pad    <= req_pad_i;
                            lat_cfg    <= req_cfg_i;
                            settle_cnt <= '0;
                            busy_o     <= 1'b1;
                            state      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_LAST) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_cfg_sequencer.sv
// Self-checking bench for io_cfg_sequencer: directed scenarios followed by
// randomized requests, all compared against a behavioural model of the pad bank.
module tb_io_cfg_sequencer;

    localparam int NP  = 8;
    localparam int CW  = 3;
    localparam int SC  = 4;
    localparam int IW  = 4;

    logic              clk_in = 1'b0;
    logic              reset_int;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [IW-1:0]     req_pad_i;
    logic [CW-1:0]     req_cfg_i;
    logic              safe_all_i;
    logic [NP*CW-1:0]  io_cell_cfg_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int test_count = 0;
    int fail_count = 0;

    // Behavioural model: pad array plus a pending change with remaining safe cycles.
    logic [CW-1:0] model_cfg [NP];
    bit            pend_active;
    int            pend_pad;
    logic [CW-1:0] pend_cfg;
    int            pend_left;
    bit            exp_done;
    bit            exp_err;

    io_cfg_sequencer #(
        .NUM_PADS      (NP),
        .CONF_WIDTH    (CW),
        .SAFE_CFG      (3'b000),
        .SETTLE_CYCLES (SC),
        .IDX_W         (IW)
    ) dut (
        .clk_in        (clk_in),
        .reset_int     (reset_int),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_pad_i     (req_pad_i),
        .req_cfg_i     (req_cfg_i),
        .safe_all_i    (safe_all_i),
        .io_cell_cfg_o (io_cell_cfg_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NP; i++) model_cfg[i] = '0;
        pend_active = 0;
        pend_pad    = 0;
        pend_cfg    = '0;
        pend_left   = 0;
        exp_done    = 0;
        exp_err     = 0;
    endtask

    // One clock edge of the model, using the inputs currently driven.
    task automatic modelUpdate();
        exp_done = 0;
        exp_err  = 0;
        if (safe_all_i) begin
            for (int i = 0; i < NP; i++) model_cfg[i] = '0;
            pend_active = 0;
        end else if (pend_active) begin
            if (pend_left == 1) begin
                model_cfg[pend_pad] = pend_cfg;
                pend_active = 0;
                exp_done = 1;
            end else begin
                pend_left--;
            end
        end else if (req_valid_i) begin
            if (int'(req_pad_i) >= NP) begin
                exp_err = 1;
            end else if (model_cfg[req_pad_i] == req_cfg_i) begin
                exp_done = 1;
            end else begin
                model_cfg[req_pad_i] = '0;
                pend_active = 1;
                pend_pad    = int'(req_pad_i);
                pend_cfg    = req_cfg_i;
                pend_left   = SC;
            end
        end
    endtask

    task automatic compareAll(input string phase);
        logic [NP*CW-1:0] exp_flat;
        for (int i = 0; i < NP; i++) exp_flat[i*CW +: CW] = model_cfg[i];
        checkOutput({phase, ".cfg"},   32'(io_cell_cfg_o), 32'(exp_flat));
        checkOutput({phase, ".busy"},  32'(busy_o),        32'(pend_active));
        checkOutput({phase, ".done"},  32'(done_o),        32'(exp_done));
        checkOutput({phase, ".err"},   32'(err_o),         32'(exp_err));
        checkOutput({phase, ".ready"}, 32'(req_ready_o),   32'(!pend_active && !safe_all_i));
        checkOutput({phase, ".excl"},  32'(done_o & err_o), 32'(0));
    endtask

    // Drive one cycle of inputs at the falling edge, advance one rising edge, then check.
    task automatic applyStimulus(input logic v, input int pad, input int cfg, input logic safe, input string phase);
        req_valid_i = v;
        req_pad_i   = IW'(pad);
        req_cfg_i   = CW'(cfg);
        safe_all_i  = safe;
        @(posedge clk_in);
        modelUpdate();
        @(negedge clk_in);
        compareAll(phase);
    endtask

    initial begin
        reset_int   = 1'b0;
        req_valid_i = 1'b0;
        req_pad_i   = '0;
        req_cfg_i   = '0;
        safe_all_i  = 1'b0;
        modelReset();

        // Reset state, then release.
        repeat (2) @(negedge clk_in);
        compareAll("rst_held");
        reset_int = 1'b1;
        @(negedge clk_in);
        compareAll("rst_rel");

        // Pad 3 to 3'b101 through the full settle sequence.
        applyStimulus(1, 3, 5, 0, "p3_acc");
        repeat (SC + 1) applyStimulus(0, 0, 0, 0, "p3_settle");

        // Same value again: immediate done, no safe dip.
        applyStimulus(1, 3, 5, 0, "p3_same");
        applyStimulus(0, 0, 0, 0, "p3_same_after");

        // Out-of-range index: error pulse only.
        applyStimulus(1, 9, 6, 0, "oor_9");
        applyStimulus(0, 0, 0, 0, "oor_after");
        applyStimulus(1, 15, 1, 0, "oor_15");

        // Safe request on a pad whose value is not safe still runs a sequence.
        applyStimulus(1, 3, 0, 0, "p3_safe");
        repeat (SC + 1) applyStimulus(0, 0, 0, 0, "p3_safe_settle");

        // Pads 0 and 1 to 3'b010, then safe_all_i two cycles into a pad 5 sequence.
        applyStimulus(1, 0, 2, 0, "p0_acc");
        repeat (SC) applyStimulus(0, 0, 0, 0, "p0_settle");
        applyStimulus(1, 1, 2, 0, "p1_acc");
        repeat (SC) applyStimulus(0, 0, 0, 0, "p1_settle");
        applyStimulus(0, 0, 0, 0, "gap");
        applyStimulus(1, 5, 7, 0, "p5_acc");
        repeat (2) applyStimulus(0, 0, 0, 0, "p5_settle");
        repeat (3) applyStimulus(1, 5, 7, 1, "safe_all");
        repeat (SC + 2) applyStimulus(0, 0, 0, 0, "safe_rel");

        // Back-to-back requests with valid held high: pad 0 then pad 7.
        applyStimulus(1, 0, 6, 0, "b2b_p0");
        repeat (2 * SC + 3) applyStimulus(1, 7, 3, 0, "b2b_p7");
        applyStimulus(0, 0, 0, 0, "b2b_end");

        // Asynchronous reset in the middle of a settle period.
        applyStimulus(1, 2, 7, 0, "rst_mid_acc");
        repeat (2) applyStimulus(0, 0, 0, 0, "rst_mid_settle");
        #2 reset_int = 1'b0;
        modelReset();
        #1 compareAll("rst_async");
        @(negedge clk_in);
        compareAll("rst_async_edge");
        reset_int = 1'b1;
        applyStimulus(0, 0, 0, 0, "rst_async_rel");

        // Randomized requests, occasional safe_all_i pulses.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(logic'($urandom_range(0, 1)),
                          int'($urandom_range(0, 9)),
                          int'($urandom_range(0, 7)),
                          logic'($urandom_range(0, 24) == 0),
                          "rand");
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
